serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
- Bit-serial (LSB-first) ripple subtractor computing diff = a - b - bin over WIDTH cycles, using one full-subtractor cell and a borrow flip-flop.
- Sequential counterpart of the combinational 4-bit ripple-carry adder path: trades area for latency.
- Used by downstream datapaths that need a - b with a borrow chain, with a start/done handshake.

Parameters:
- WIDTH, 4, operand/result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- ready  output  1  high when a start will be accepted (IDLE or DONE).
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse when diff/bout are valid and new.
- diff  output  WIDTH  result a - b - bin mod 2^WIDTH; held until the next completion.
- bout  output  1  final borrow-out (1 when a < b + bin unsigned); held with diff.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE.
  - ready=1, busy=0, done=0, diff=0, bout=0.
  - Internal shift registers, borrow FF and bit counter are cleared.
  - Reset wins over any other input in the same cycle.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE (ready=1):
  - start=1 at an edge: latch a, b into shift registers, borrow FF <= bin, counter <= 0, go to RUN.
  - start=0: stay in IDLE.
- RUN (busy=1, ready=0):
  - Each edge processes bit x = a_sh[0], y = b_sh[0], c = borrow FF.
  - d = x ^ y ^ c.
  - borrow <= (~x & y) | (~(x ^ y) & c).
  - d shifts into the MSB of the result shift register; a_sh and b_sh shift right.
  - counter increments.
  - start is ignored.
  - On the edge processing bit WIDTH-1: diff <= completed result, bout <= final borrow, done <= 1, go to DONE.
- DONE (ready=1, busy=0, done=1 for exactly this one cycle):
  - start=1 at an edge: accept as in IDLE and go straight to RUN. Back-to-back operation with no idle gap.
  - Otherwise go to IDLE; done drops.
- Latency: start sampled at edge T, done=1 after edge T+WIDTH. Throughput is one result per WIDTH cycles.
- diff/bout change only at completion. Partial results are never visible.
- Operands are latched, so a/b/bin may change freely after acceptance.
- Wrap-around: result is modulo 2^WIDTH. bout=1 flags an unsigned underflow.
- Reset asserted mid-RUN: abort; no done pulse; outputs go to their reset values.

Test Plan:
- WIDTH=4, a=9, b=3, bin=0, start for 1 cycle -> busy for 4 cycles, then done=1 for 1 cycle; diff=6, bout=0. ready=0 during RUN.
- a=3, b=5, bin=0 -> diff=14, bout=1. Also a=0, b=0, bin=1 -> diff=15, bout=1. Also a=15, b=15, bin=0 -> diff=0, bout=0.
- Start a=9, b=3; pulse start again with a=1, b=1 during RUN -> second request ignored; result diff=6; exactly one done pulse.
- start held high continuously with a new operand set applied each DONE cycle (8-2, then 4-7) -> results 6/bout0, then 13/bout1; done pulses spaced exactly 5 cycles apart; diff stable between pulses.
- Start 9-3, assert rst_n=0 on the 2nd RUN cycle -> no done pulse; diff=0, bout=0, ready=1 on the next cycle. A subsequent 7-2 gives diff=5.
- WIDTH=8: a=0, b=1, bin=0 -> diff=255, bout=1 after 8 RUN cycles. Also a=200, b=55, bin=1 -> diff=144, bout=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH clocks using
// one full-subtractor cell, a borrow flop and a start/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic [1:0]       fs_s;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic c);
        logic d_bit;
        logic b_out;
        d_bit = x ^ y ^ c;
        b_out = (~x & y) | (~(x ^ y) & c);
        return {b_out, d_bit};
    endfunction

    assign fs_s = full_sub(a_sh_q[0], b_sh_q[0], brw_q);

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d  = {fs_s[0], res_q[WIDTH-1:1]};
                brw_d  = fs_s[1];
                cnt_d  = cnt_q + CNT_W'(1);
                // Publish only once the final bit lands so partial results stay hidden.
                if (cnt_q == LAST_BIT) begin
                    diff_d  = {fs_s[0], res_q[WIDTH-1:1]};
                    bout_d  = fs_s[1];
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_RUN);
        busy_d  = (state_d == ST_RUN);
        done_d  = (state_q == ST_RUN) && (state_d == ST_DONE);
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign ready = ready_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign bout  = bout_q;

endmodule
